data_memory_ctrl: RTL
=====================

Name: data_memory_ctrl

Overview:
Byte-addressable RV32 data memory with a valid/ready request port and a registered, fixed-latency response port. Handles all RV32I load/store widths via func3, with sign/zero extension and little-endian byte order. Detects out-of-range, illegal-func3 and misaligned accesses. Sits in the MEM stage; the pipeline stalls on req_ready/rsp_valid.

Parameters:
ADDR_WIDTH, 32, width of req_addr.
DEPTH_BYTES, 1024, memory size in bytes; power of two, at least 4.
READ_LATENCY, 1, cycles from the acceptance edge to rsp_valid; legal range 1..4.

Ports:
clk  input  1  clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-low reset.
req_valid  input  1  request present.
req_ready  output  1  block can accept a request this cycle.
req_write  input  1  1 = store, 0 = load.
req_func3  input  3  RV32I width/sign code.
req_addr  input  ADDR_WIDTH  byte address.
req_wdata  input  32  store data; low bytes are used.
rsp_valid  output  1  one-cycle response strobe.
rsp_rdata  output  32  load result (extended); 0 for stores and errors.
rsp_err  output  1  access faulted; qualified by rsp_valid.

Behaviour:
- Reset asserted (reset=0): FSM goes to IDLE; req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0. Memory array is not cleared.
- First cycle after reset release: req_ready=1.
- req_ready=1 only in state IDLE. Only one request is outstanding at a time.
- A request is accepted on an edge where req_valid && req_ready.
- FSM states:
  - IDLE: on accept, go to RESP if READ_LATENCY=1; otherwise go to WAIT and load a counter with READ_LATENCY-1.
  - WAIT: decrement the counter each cycle; go to RESP when the counter reaches 1.
  - RESP: rsp_valid=1 for exactly this one cycle; return to IDLE.
- Throughput: one request every READ_LATENCY+1 cycles.
- Acceptance edge:
  - Classify the request and compute its error status.
  - A legal store writes memory on this edge.
  - A legal load captures and extends its data into a response register on this edge.
  - rsp_rdata and rsp_err are driven from these registers during RESP. rsp_rdata holds its value after RESP until the next response.
- Byte index = req_addr[log2(DEPTH_BYTES)-1:0].
- Out-of-range: any nonzero req_addr bit above the index bits gives rsp_err=1, rsp_rdata=0, and no write.
- func3 decode:
  - Loads: 000 LB (sign), 001 LH (sign), 010 LW, 100 LBU (zero), 101 LHU (zero).
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other code: rsp_err=1, rsp_rdata=0, no write.
- Byte order: little-endian. Byte at index i lands in bits [7:0]; byte at i+1 lands in bits [15:8], and so on.
- Stores update only the addressed bytes; all other bytes are untouched.
- Alignment: halfword is misaligned when addr[0]=1; word is misaligned when addr[1:0]≠0. See Optional Feature.
- req_valid asserted while req_ready=0 is ignored and not queued; the requester must hold it.
- Reset mid-operation:
  - The pending response is dropped; no rsp_valid is produced.
  - A store accepted before reset stays committed.
- Inputs while in WAIT/RESP have no effect.

Optional Feature:
DMEM_MISALIGN_TRAP_EN
- Defined: a misaligned access gives rsp_err=1 and rsp_rdata=0; no bytes are written.
- Undefined: a misaligned access is performed bytewise at consecutive indices, wrapping modulo DEPTH_BYTES, with rsp_err=0.
- Example (undefined): LW at index DEPTH_BYTES-2 reads bytes DEPTH_BYTES-2, DEPTH_BYTES-1, 0, 1.
- Out-of-range and illegal-func3 errors apply in both builds.

Test Plan:
- Reset release, READ_LATENCY=1 -> req_ready=1 in the first cycle after release. SW addr 0x10 data 0xDEADBEEF is accepted; rsp_valid pulses the next cycle with rsp_err=0. LW 0x10 returns 0xDEADBEEF.
- After the above: LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x12 -> 0xFFFFDEAD; LHU 0x10 -> 0x0000BEEF.
- SB 0x11 data 0x00000055, then LW 0x10 -> 0xDEAD55EF. SH 0x12 data 0x1234, then LW 0x10 -> 0x123455EF.
- READ_LATENCY=3:
  - rsp_valid appears exactly 3 cycles after acceptance.
  - req_ready stays 0 for 3 cycles.
  - A req_valid held across the busy cycles is accepted on the 4th edge after the first acceptance.
- LW addr 0x00010000 (DEPTH_BYTES=1024) -> rsp_err=1, rsp_rdata=0. func3=011 load -> rsp_err=1. SW with func3=100 -> rsp_err=1 and memory unchanged.
- LW 0x11 with the trap defined -> rsp_err=1, rsp_rdata=0. Without it, with memory holding 0xDEAD55EF at 0x10 and 0x00000000 at 0x14 -> rsp_rdata=0x00DEAD55, rsp_err=0. Also: reset asserted during WAIT -> no rsp_valid, req_ready=1 after release.

Source files
------------

// File: rtl/data_memory_ctrl.sv
// data_memory_ctrl: byte-addressable RV32 data memory for the MEM stage.
// valid/ready request port, registered fixed-latency response strobe.
// Build option: define DMEM_MISALIGN_TRAP_EN to fault misaligned accesses;
// otherwise they are performed bytewise with index wrap-around.
module data_memory_ctrl #(
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned DEPTH_BYTES  = 1024,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [2:0]            req_func3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_err
);

    localparam int unsigned IDX_W = $clog2(DEPTH_BYTES);
    localparam int unsigned CNT_W = 3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [31:0]        hold_rdata;
    logic               hold_err;

    logic [7:0]         mem [DEPTH_BYTES];

    logic [IDX_W-1:0]   idx0_c, idx1_c, idx2_c, idx3_c;
    logic [7:0]         b0_c, b1_c, b2_c, b3_c;
    logic [1:0]         size_c;
    logic               legal_c;
    logic               oor_c;
    logic               err_c;
    logic               accept_c;
    logic               wr_en_c;
    logic [31:0]        load_data_c;

    // Consecutive byte indices; wrap modulo DEPTH_BYTES falls out of the index width
    always_comb begin
        idx0_c = req_addr[IDX_W-1:0];
        idx1_c = idx0_c + IDX_W'(1);
        idx2_c = idx0_c + IDX_W'(2);
        idx3_c = idx0_c + IDX_W'(3);
        b0_c   = mem[idx0_c];
        b1_c   = mem[idx1_c];
        b2_c   = mem[idx2_c];
        b3_c   = mem[idx3_c];
    end

    // Request classification: legality, range and alignment faults
    always_comb begin
        size_c  = req_func3[1:0];
        legal_c = 1'b0;
        if (req_write) begin
            legal_c = (req_func3 == 3'b000) || (req_func3 == 3'b001) ||
                      (req_func3 == 3'b010);
        end else begin
            legal_c = (req_func3 == 3'b000) || (req_func3 == 3'b001) ||
                      (req_func3 == 3'b010) || (req_func3 == 3'b100) ||
                      (req_func3 == 3'b101);
        end
        oor_c = (req_addr >> IDX_W) != '0;
`ifdef DMEM_MISALIGN_TRAP_EN
        err_c = oor_c || !legal_c ||
                ((size_c == 2'b01) && req_addr[0]) ||
                ((size_c == 2'b10) && (req_addr[1:0] != 2'b00));
`else
        err_c = oor_c || !legal_c;
`endif
        accept_c = req_valid && req_ready;
        wr_en_c  = accept_c && req_write && !err_c;
    end

    // Little-endian load assembly with sign/zero extension
    always_comb begin
        load_data_c = 32'h0;
        case (req_func3)
            3'b000:  load_data_c = {{24{b0_c[7]}}, b0_c};
            3'b001:  load_data_c = {{16{b1_c[7]}}, b1_c, b0_c};
            3'b010:  load_data_c = {b3_c, b2_c, b1_c, b0_c};
            3'b100:  load_data_c = {24'h0, b0_c};
            3'b101:  load_data_c = {16'h0, b1_c, b0_c};
            default: load_data_c = 32'h0;
        endcase
        if (err_c || req_write) begin
            load_data_c = 32'h0;
        end
    end

    // Byte-lane store; only the addressed bytes change, array is never reset
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            mem[idx0_c] <= req_wdata[7:0];
            if (size_c != 2'b00) begin
                mem[idx1_c] <= req_wdata[15:8];
            end
            if (size_c == 2'b10) begin
                mem[idx2_c] <= req_wdata[23:16];
                mem[idx3_c] <= req_wdata[31:24];
            end
        end
    end

    // Request/response FSM with registered handshake and response outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            hold_rdata <= 32'h0;
            hold_err   <= 1'b0;
            req_ready  <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= 32'h0;
            rsp_err    <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept_c) begin
                        hold_rdata <= load_data_c;
                        hold_err   <= err_c;
                        req_ready  <= 1'b0;
                        if (READ_LATENCY <= 1) begin
                            state     <= S_RESP;
                            rsp_valid <= 1'b1;
                            rsp_rdata <= load_data_c;
                            rsp_err   <= err_c;
                        end else begin
                            state <= S_WAIT;
                            cnt   <= CNT_W'(READ_LATENCY - 1);
                        end
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                S_WAIT: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state     <= S_RESP;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= hold_rdata;
                        rsp_err   <= hold_err;
                    end
                end
                S_RESP: begin
                    state     <= S_IDLE;
                    req_ready <= 1'b1;
                    rsp_err   <= 1'b0;
                end
                default: begin
                    state     <= S_IDLE;
                    req_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule
